sdio_cmd_capture: RTL and testbench
===================================

# sdio_cmd_capture

Captures SDIO CMD-line frames in the system `clk` domain by oversampling `sd_clk` and `cmd_i`. Decodes each 48-bit frame into index and argument, checks CRC7 and the end bit, and reports it with a one-cycle strobe. It sits directly upstream of `ctrl`: its `cmd_o`, `arg_o` and `finsh_o` drive `ctrl`'s `cmd_dat_i`, `arg_i` and `finsh_i`. It replaces the `sd_clk`-domain sampler with a single-clock design.

## Interface
Clocking is fixed: one clock; reset is asynchronous and active-high (ports `clk`, `rst`).

Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth for `sd_clk` and `cmd_i`. Legal range is 2..4.
- `TIMEOUT`, default 1024: number of `clk` cycles with no `sd_clk` rising edge before a partial frame is abandoned.

Ports:
- `clk` in 1: system clock. Must run at 4× or more the `sd_clk` frequency.
- `rst` in 1: asynchronous active-high reset.
- `sd_clk` in 1: raw SDIO clock, sampled as data.
- `cmd_i` in 1: raw SDIO CMD line.
- `cmd_o` out 8: frame bits [47:40], i.e. {start, dir, index[5:0]}.
- `arg_o` out 32: frame bits [39:8].
- `crc_o` out 7: received CRC7, frame bits [7:1].
- `finsh_o` out 1: one-cycle strobe; the frame outputs are valid from this cycle on.
- `frame_err_o` out 1: one-cycle strobe on a CRC, end-bit or timeout error.
- `busy_o` out 1: high while a frame is being shifted in.
- `status` out 8: bit 7 = CRC error on last frame; bit 6 = end-bit error on last frame; bit 5 = timeout on last frame; bit 4 = dir bit of last frame; bits 3:0 = good-frame counter, mod 16.

## Operation
- Synchronizers:
  - `sd_clk` and `cmd_i` pass through equal-depth chains, so they stay aligned.
  - A rising-edge tick `rise` is high for one `clk` cycle when the synchronized `sd_clk` goes 0→1.
  - `cmd_i` is sampled only on `rise`.
- FSM states:
  - IDLE: on `rise` with cmd=0, load bit 47 = 0, set bit count to 46 and go to SHIFT. `rise` with cmd=1 is ignored.
  - SHIFT: on each `rise`, shift cmd into the 48-bit register and decrement the count. When the count reaches 0 (48th bit), go to CHECK.
    - If `TIMEOUT` cycles pass with no `rise`, go to ABORT.
  - CHECK (one cycle):
    - Compare the serially computed CRC7 over bits [47:8] with bits [7:1].
    - Check that bit 0 is 1.
    - Update the outputs and status, pulse `finsh_o`, then go to IDLE.
  - ABORT (one cycle): set status[5], pulse `frame_err_o`, leave `cmd_o`/`arg_o`/`crc_o` unchanged, go to IDLE.
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0.
  - Advanced on each of the first 40 sampled bits, then frozen.
- `finsh_o` pulses for every completed frame, including errored ones.
  - `frame_err_o` pulses in the same cycle when the CRC or end bit is bad.
  - The counter increments only on frames with no error.
- Both host commands (dir=1) and 48-bit card responses (dir=0) are captured. R2 (136-bit) responses are unsupported: they are reported as a frame error or produce garbage frames.
- `finsh_o` has no back-pressure. Each new frame overwrites the outputs; the consumer must latch on the strobe.
- `busy_o` is high in SHIFT and CHECK.

## Timing
- Reset values:
  - All outputs are 0.
  - FSM is in IDLE.
  - `cmd_i` synchronizer stages reset to 1 (idle line high), so reset release can never produce a false start.
  - `sd_clk` synchronizer stages reset to 0. A spurious `rise` just after reset is harmless because cmd=1.
- Latency:
  - From a raw `sd_clk` edge to `rise` is `SYNC_STAGES`+1 `clk` cycles.
  - `finsh_o` asserts exactly 1 `clk` cycle after the `rise` that samples bit 0.
- A `rise` during CHECK or ABORT is impossible at 4× oversampling and is not required to be handled.
- `rst` asserted mid-frame clears immediately to IDLE. The partial frame is discarded and no strobe is issued.
- Back-to-back frames: a start bit on the first `rise` after CHECK is accepted.
- The counter wraps from 15 to 0.

## Structure
- Package `sdio_pkg`:
  - `SDIO_FRAME_BITS`=48
  - `SDIO_CRC7_POLY`=7'h09
  - FSM state enum {IDLE, SHIFT, CHECK, ABORT}
  - status bit index constants
- Sub-module `sdio_crc7`: serial CRC7 with `clr`, `en` and `din` inputs and a `crc[6:0]` output.

## Test plan
- CMD0, bytes 40 00 00 00 00 95 → `finsh_o` pulses once, `cmd_o`=8'h40, `arg_o`=0, `crc_o`=7'h4A, no `frame_err_o`, status[3:0]=1.
- CMD8, bytes 48 00 00 01 AA 87 → `cmd_o`=8'h48, `arg_o`=32'h000001AA, `crc_o`=7'h43, status[3:0] increments.
- CMD17 with CRC byte 0x57 instead of 0x55 → `finsh_o` and `frame_err_o` pulse together, status[7]=1, counter unchanged.
- CMD0 followed immediately (next edge) by CMD17 (51 00 00 00 00 55) → two `finsh_o` pulses, and the final `cmd_o`=8'h51.
- Stop `sd_clk` after 20 bits for more than `TIMEOUT` cycles → `frame_err_o` pulses, status[5]=1, `busy_o` falls, outputs keep the previous frame.
- Assert `rst` after 30 bits, release it, then send CMD0 → no strobe during the aborted frame, and the next frame decodes correctly.

Source files
------------

// File: rtl/sdio_pkg.sv
// Shared constants, FSM encoding and the CRC7 step function for the SDIO CMD-line capture block.
package sdio_pkg;

  localparam int SDIO_FRAME_BITS = 48;
  localparam logic [6:0] SDIO_CRC7_POLY = 7'h09;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2,
    ABORT = 2'd3
  } sdio_state_e;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_ABORT = 2'd3;

  localparam int STAT_CRC_ERR = 7;
  localparam int STAT_END_ERR = 6;
  localparam int STAT_TIMEOUT = 5;
  localparam int STAT_DIR     = 4;

  // One serial step of CRC7 (x^7 + x^3 + 1), MSB-first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? SDIO_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sdio_crc7.sv
// Serial CRC7 accumulator; clr restarts from zero and may absorb a bit in the same cycle.
module sdio_crc7
  import sdio_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic [6:0] crc_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_reg <= '0;
    end else if (clr) begin
      crc_reg <= en ? crc7_step(7'h00, din) : 7'h00;
    end else if (en) begin
      crc_reg <= crc7_step(crc_reg, din);
    end
  end

  assign crc = crc_reg;

endmodule

// File: rtl/sdio_cmd_capture.sv
// Oversampling SDIO CMD-line frame capture: synchronizes sd_clk/cmd_i into clk,
// shifts in 48-bit frames, checks CRC7 and end bit, and strobes the decoded fields.
module sdio_cmd_capture
  import sdio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sd_clk,
  input  logic        cmd_i,
  output logic [7:0]  cmd_o,
  output logic [31:0] arg_o,
  output logic [6:0]  crc_o,
  output logic        finsh_o,
  output logic        frame_err_o,
  output logic        busy_o,
  output logic [7:0]  status
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  logic [SYNC_STAGES-1:0] sd_sync_reg;
  logic [SYNC_STAGES-1:0] cmd_sync_reg;
  logic                   sd_prev_reg;
  logic                   rise_reg;
  logic                   cmd_bit_reg;

  logic [1:0]                 state_reg;
  logic [5:0]                 bit_cnt_reg;
  logic [SDIO_FRAME_BITS-1:0] shift_reg;
  logic [SDIO_FRAME_BITS-1:0] frame_next;
  logic [TW-1:0]              idle_cnt_reg;

  logic [7:0]  cmd_reg;
  logic [31:0] arg_reg;
  logic [6:0]  crc_out_reg;
  logic        finsh_reg;
  logic        frame_err_reg;
  logic [7:0]  status_reg;

  logic       crc_clr;
  logic       crc_en;
  logic [6:0] crc_val;
  logic       crc_bad;
  logic       end_bad;

  // cmd chain idles high so leaving reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sd_sync_reg  <= '0;
      cmd_sync_reg <= '1;
      sd_prev_reg  <= 1'b0;
      rise_reg     <= 1'b0;
      cmd_bit_reg  <= 1'b1;
    end else begin
      sd_sync_reg  <= {sd_sync_reg[SYNC_STAGES-2:0], sd_clk};
      cmd_sync_reg <= {cmd_sync_reg[SYNC_STAGES-2:0], cmd_i};
      sd_prev_reg  <= sd_sync_reg[SYNC_STAGES-1];
      rise_reg     <= sd_sync_reg[SYNC_STAGES-1] & ~sd_prev_reg;
      cmd_bit_reg  <= cmd_sync_reg[SYNC_STAGES-1];
    end
  end

  always_comb begin
    frame_next = {shift_reg[SDIO_FRAME_BITS-2:0], cmd_bit_reg};
    crc_clr    = (state_reg == ST_IDLE) && rise_reg && !cmd_bit_reg;
    crc_en     = crc_clr || ((state_reg == ST_SHIFT) && rise_reg && (bit_cnt_reg >= 6'd8));
    crc_bad    = (crc_val != frame_next[7:1]);
    end_bad    = ~frame_next[0];
  end

  sdio_crc7 u_crc7 (
    .clk (clk),
    .rst (rst),
    .clr (crc_clr),
    .en  (crc_en),
    .din (cmd_bit_reg),
    .crc (crc_val)
  );

  // The check is evaluated on the final-bit rise so the results are already
  // registered during the CHECK cycle, which is when finsh_o is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      idle_cnt_reg  <= '0;
      cmd_reg       <= '0;
      arg_reg       <= '0;
      crc_out_reg   <= '0;
      finsh_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      status_reg    <= '0;
    end else begin
      finsh_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (rise_reg && !cmd_bit_reg) begin
            shift_reg    <= '0;
            bit_cnt_reg  <= 6'd46;
            idle_cnt_reg <= '0;
            state_reg    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (rise_reg) begin
            shift_reg    <= frame_next;
            idle_cnt_reg <= '0;
            if (bit_cnt_reg == 6'd0) begin
              cmd_reg                  <= frame_next[47:40];
              arg_reg                  <= frame_next[39:8];
              crc_out_reg              <= frame_next[7:1];
              status_reg[STAT_CRC_ERR] <= crc_bad;
              status_reg[STAT_END_ERR] <= end_bad;
              status_reg[STAT_TIMEOUT] <= 1'b0;
              status_reg[STAT_DIR]     <= frame_next[46];
              if (!crc_bad && !end_bad) begin
                status_reg[3:0] <= status_reg[3:0] + 4'd1;
              end
              finsh_reg     <= 1'b1;
              frame_err_reg <= crc_bad | end_bad;
              state_reg     <= ST_CHECK;
            end else begin
              bit_cnt_reg <= bit_cnt_reg - 6'd1;
            end
          end else if (idle_cnt_reg == TW'(TIMEOUT - 1)) begin
            status_reg[STAT_CRC_ERR] <= 1'b0;
            status_reg[STAT_END_ERR] <= 1'b0;
            status_reg[STAT_TIMEOUT] <= 1'b1;
            frame_err_reg            <= 1'b1;
            state_reg                <= ST_ABORT;
          end else begin
            idle_cnt_reg <= idle_cnt_reg + TW'(1);
          end
        end
        ST_CHECK: state_reg <= ST_IDLE;
        default:  state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_o       = cmd_reg;
  assign arg_o       = arg_reg;
  assign crc_o       = crc_out_reg;
  assign finsh_o     = finsh_reg;
  assign frame_err_o = frame_err_reg;
  assign busy_o      = (state_reg == ST_SHIFT) || (state_reg == ST_CHECK);
  assign status      = status_reg;

endmodule

// File: tb/tb_sdio_cmd_capture.sv
// Directed bench for sdio_cmd_capture: bit-bangs sd_clk/cmd_i frames and checks decoded results.
module tb_sdio_cmd_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        sd_clk;
  logic        cmd_i;
  logic [7:0]  cmd_o;
  logic [31:0] arg_o;
  logic [6:0]  crc_o;
  logic        finsh_o;
  logic        frame_err_o;
  logic        busy_o;
  logic [7:0]  status;

  int n_cmp = 0;
  int n_bad = 0;
  int fin_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #5 clk = ~clk;

  sdio_cmd_capture dut (
    .clk         (clk),
    .rst         (rst),
    .sd_clk      (sd_clk),
    .cmd_i       (cmd_i),
    .cmd_o       (cmd_o),
    .arg_o       (arg_o),
    .crc_o       (crc_o),
    .finsh_o     (finsh_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o),
    .status      (status)
  );

  always @(negedge clk) begin
    if (finsh_o) fin_cnt++;
    if (frame_err_o) err_cnt++;
    if (finsh_o && frame_err_o) both_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Sends the top nbits of frame MSB-first; 8 clk periods per sd_clk period.
  task automatic send_bits(input logic [47:0] frame, input int nbits);
    for (int i = 47; i > 47 - nbits; i--) begin
      sd_clk = 1'b0;
      cmd_i  = frame[i];
      #40;
      sd_clk = 1'b1;
      #40;
    end
  endtask

  task automatic idle_line(input int cycles);
    sd_clk = 1'b0;
    cmd_i  = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    rst    = 1'b1;
    sd_clk = 1'b0;
    cmd_i  = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_cmd_o", cmd_o, 8'h00);
    chk("rst_arg_o", arg_o, 32'h0);
    chk("rst_status", status, 8'h00);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_finsh", finsh_o, 1'b0);
    rst = 1'b0;
    idle_line(10);

    // CMD0
    send_bits(48'h40_00000000_95, 48);
    idle_line(10);
    chk("cmd0_fin", fin_cnt, 1);
    chk("cmd0_err", err_cnt, 0);
    chk("cmd0_cmd", cmd_o, 8'h40);
    chk("cmd0_arg", arg_o, 32'h0);
    chk("cmd0_crc", crc_o, 7'h4A);
    chk("cmd0_status", status, 8'h11);

    // CMD8
    send_bits(48'h48_000001AA_87, 48);
    idle_line(10);
    chk("cmd8_fin", fin_cnt, 2);
    chk("cmd8_cmd", cmd_o, 8'h48);
    chk("cmd8_arg", arg_o, 32'h000001AA);
    chk("cmd8_crc", crc_o, 7'h43);
    chk("cmd8_status", status, 8'h12);

    // CMD17 with corrupted CRC
    send_bits(48'h51_00000000_57, 48);
    idle_line(10);
    chk("badcrc_fin", fin_cnt, 3);
    chk("badcrc_err", err_cnt, 1);
    chk("badcrc_together", both_cnt, 1);
    chk("badcrc_crc", crc_o, 7'h2B);
    chk("badcrc_status", status, 8'h92);

    // Back-to-back CMD0 then CMD17
    send_bits(48'h40_00000000_95, 48);
    send_bits(48'h51_00000000_55, 48);
    idle_line(10);
    chk("b2b_fin", fin_cnt, 5);
    chk("b2b_err", err_cnt, 1);
    chk("b2b_cmd", cmd_o, 8'h51);
    chk("b2b_crc", crc_o, 7'h2A);
    chk("b2b_status", status, 8'h14);

    // Timeout after 20 bits
    send_bits(48'h48_000001AA_87, 20);
    @(negedge clk);
    chk("to_busy_mid", busy_o, 1'b1);
    idle_line(1100);
    chk("to_err", err_cnt, 2);
    chk("to_fin", fin_cnt, 5);
    chk("to_status", status, 8'h34);
    chk("to_cmd_kept", cmd_o, 8'h51);
    chk("to_crc_kept", crc_o, 7'h2A);
    chk("to_busy", busy_o, 1'b0);

    // Reset mid-frame, then CMD0
    send_bits(48'h48_000001AA_87, 30);
    sd_clk = 1'b0;
    cmd_i  = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_status", status, 8'h00);
    chk("mid_rst_cmd", cmd_o, 8'h00);
    chk("mid_rst_busy", busy_o, 1'b0);
    chk("mid_rst_fin", fin_cnt, 5);
    idle_line(10);
    send_bits(48'h40_00000000_95, 48);
    idle_line(10);
    chk("post_rst_fin", fin_cnt, 6);
    chk("post_rst_err", err_cnt, 2);
    chk("post_rst_cmd", cmd_o, 8'h40);
    chk("post_rst_crc", crc_o, 7'h4A);
    chk("post_rst_status", status, 8'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
